// File: rtl/alu_types_pkg.sv
// Shared ALU operation encodings and helpers for the
// request arbiter and its round-robin grant logic.
package alu_types_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_MUL = 3'd2
   } operation_t;

   // Only add/sub/mul are implemented; anything else is
   // still issued but flagged back to the requester.
   function automatic logic is_legal_op(operation_t op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: search from pointer
// upward with wrap, first pending request wins.
module rr_arbiter #(
   parameter int NREQ = 4,
   localparam int IDW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  pointer,
   input  logic            enable,
   output logic [NREQ-1:0] grant
);

   logic [IDW:0]   sum;
   logic [IDW-1:0] idx;
   logic           found;

   // Scan requesters starting at the pointer, wrapping at NREQ
   always_comb begin
      grant = '0;
      found = 1'b0;
      sum   = '0;
      idx   = '0;
      for (int i = 0; i < NREQ; i++) begin
         sum = {1'b0, pointer} + (IDW+1)'(i);
         if (sum >= (IDW+1)'(NREQ)) begin
            sum = sum - (IDW+1)'(NREQ);
         end
         idx = sum[IDW-1:0];
         if (enable && !found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one pipelined ALU among NREQ requesters and routes
// each result back to its originator via a tag pipeline.
module alu_req_arbiter
   import alu_types_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int WIDTH   = 6,
   parameter int ALU_LAT = 2,
   parameter int IDW     = $clog2(NREQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   hold,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ*OP_W-1:0]   req_op,
   input  logic [NREQ*WIDTH-1:0]  req_a,
   input  logic [NREQ*WIDTH-1:0]  req_b,
   output logic [OP_W-1:0]        alu_op,
   output logic [WIDTH-1:0]       alu_a,
   output logic [WIDTH-1:0]       alu_b,
   output logic                   alu_in_valid,
   input  logic [WIDTH:0]         alu_out,
   input  logic                   alu_out_valid,
   output logic [NREQ-1:0]        rsp_valid,
   output logic [WIDTH:0]         rsp_data,
   output logic                   rsp_err,
   output logic                   busy,
   output logic                   tag_err
);

   typedef struct packed {
      logic           valid;
      logic [IDW-1:0] id;
      logic           illegal;
   } tag_t;

   logic [IDW-1:0]   pointer;
   logic [IDW-1:0]   next_ptr;
   logic [NREQ-1:0]  grant;
   logic             any_grant;
   logic [IDW-1:0]   win_id;
   logic [OP_W-1:0]  win_op;
   logic [WIDTH-1:0] win_a;
   logic [WIDTH-1:0] win_b;
   tag_t             new_tag;
   tag_t             tags [ALU_LAT];
   tag_t             last;
   logic             hit;

   // Reset also blocks grants so nothing is accepted while
   // the ALU pipeline is being cleared.
   rr_arbiter #(
      .NREQ(NREQ)
   ) u_rr (
      .req(req_valid),
      .pointer(pointer),
      .enable(~hold & ~rst),
      .grant(grant)
   );

   assign any_grant = |grant;
   assign req_ready = grant;

   // Encode the winner and mux its payload toward the ALU
   always_comb begin
      win_id = '0;
      win_op = '0;
      win_a  = '0;
      win_b  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            win_id = IDW'(i);
            win_op = req_op[i*OP_W +: OP_W];
            win_a  = req_a[i*WIDTH +: WIDTH];
            win_b  = req_b[i*WIDTH +: WIDTH];
         end
      end
   end

   assign alu_op       = win_op;
   assign alu_a        = win_a;
   assign alu_b        = win_b;
   assign alu_in_valid = any_grant;

   // Next pointer is the slot just past the winner
   always_comb begin
      next_ptr = win_id + 1'b1;
      if (win_id == IDW'(NREQ-1)) begin
         next_ptr = '0;
      end
   end

   // Pointer advances only on a grant, so hold freezes it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pointer <= '0;
      end else if (any_grant) begin
         pointer <= next_ptr;
      end
   end

   // Tag that travels alongside the operation in the ALU
   always_comb begin
      new_tag.valid   = any_grant;
      new_tag.id      = win_id;
      new_tag.illegal = any_grant &
                        ~is_legal_op(operation_t'(win_op));
   end

   // Tag shift register matched to the ALU latency
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ALU_LAT; i++) begin
            tags[i] <= '0;
         end
      end else begin
         tags[0] <= new_tag;
         for (int i = 1; i < ALU_LAT; i++) begin
            tags[i] <= tags[i-1];
         end
      end
   end

   assign last = tags[ALU_LAT-1];
   assign hit  = alu_out_valid & last.valid;

   // Route a matched ALU result back to its requester
   always_comb begin
      rsp_valid = '0;
      rsp_data  = '0;
      rsp_err   = 1'b0;
      if (hit) begin
         rsp_valid = NREQ'(1) << last.id;
         rsp_data  = alu_out;
         rsp_err   = last.illegal;
      end
   end

   // Anything still travelling through the ALU
   always_comb begin
      busy = 1'b0;
      for (int i = 0; i < ALU_LAT; i++) begin
         busy = busy | tags[i].valid;
      end
   end

   // Sticky flag for ALU strobes that disagree with the tags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_err <= 1'b0;
      end else if (alu_out_valid != last.valid) begin
         tag_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Testbench for alu_req_arbiter with a 2-stage ALU model
// and a response scoreboard.
module tb_alu_req_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 6;

   logic        clk = 1'b0;
   logic        rst;
   logic        hold;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [11:0] req_op;
   logic [23:0] req_a;
   logic [23:0] req_b;
   logic [2:0]  alu_op;
   logic [5:0]  alu_a;
   logic [5:0]  alu_b;
   logic        alu_in_valid;
   logic [6:0]  alu_out;
   logic        alu_out_valid;
   logic [3:0]  rsp_valid;
   logic [6:0]  rsp_data;
   logic        rsp_err;
   logic        busy;
   logic        tag_err;

   logic        force_ov;
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   alu_req_arbiter #(
      .NREQ(NREQ), .WIDTH(WIDTH), .ALU_LAT(2)
   ) dut (
      .clk(clk), .rst(rst), .hold(hold),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_in_valid(alu_in_valid),
      .alu_out(alu_out), .alu_out_valid(alu_out_valid),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .rsp_err(rsp_err), .busy(busy), .tag_err(tag_err)
   );

   // ALU environment: registered inputs, registered outputs
   logic       iv, ov;
   logic [2:0] iop;
   logic [5:0] ia, ib;
   logic [6:0] ores;

   function automatic logic [6:0] alu_fn(logic [2:0] op,
                                         logic [5:0] a,
                                         logic [5:0] b);
      logic [11:0] p;
      p = a * b;
      case (op)
         3'd0: return {1'b0, a} + {1'b0, b};
         3'd1: return {1'b0, a} - {1'b0, b};
         3'd2: return p[6:0];
         default: return 7'd0;
      endcase
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         iv <= 0; iop <= 0; ia <= 0; ib <= 0;
         ov <= 0; ores <= 0;
      end else begin
         iv <= alu_in_valid; iop <= alu_op;
         ia <= alu_a; ib <= alu_b;
         ov <= iv; ores <= alu_fn(iop, ia, ib);
      end
   end

   assign alu_out_valid = ov | force_ov;
   assign alu_out = ores;

   // Independent integer reference for expected results
   function automatic logic [6:0] model(logic [2:0] op,
                                        logic [5:0] a,
                                        logic [5:0] b);
      int r;
      case (op)
         3'd0: r = (int'(a) + int'(b)) % 128;
         3'd1: r = (int'(a) - int'(b) + 128) % 128;
         3'd2: r = (int'(a) * int'(b)) % 128;
         default: r = 0;
      endcase
      return 7'(r);
   endfunction

   typedef struct {
      int         id;
      logic [6:0] data;
      logic       err;
      int         due;
   } exp_t;

   exp_t sb[$];

   // Scoreboard: push on accept, pop/compare on response
   exp_t       e;
   int         gid;
   int         nbits;
   logic [2:0] gop;
   logic [5:0] ga, gb;
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
      end else begin
         if (sb.size() > 0 && sb[0].due < cyc) begin
            checks++; failures++;
            $display("FAIL sb_missing id=%0d due=%0d now=%0d",
                     sb[0].id, sb[0].due, cyc);
            void'(sb.pop_front());
         end
         if (rsp_valid != 0) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL sb_unexpected rsp_valid=%b data=%0d",
                        rsp_valid, rsp_data);
            end else begin
               e = sb.pop_front();
               if (rsp_valid !== (4'b0001 << e.id) ||
                   rsp_data !== e.data || rsp_err !== e.err ||
                   cyc != e.due) begin
                  failures++;
                  $display("FAIL sb_rsp got v=%b d=%0d e=%b c=%0d exp v=%b d=%0d e=%b c=%0d",
                           rsp_valid, rsp_data, rsp_err, cyc,
                           4'b0001 << e.id, e.data, e.err, e.due);
               end
            end
         end
         checks++;
         if (req_ready == 0) begin
            if (alu_in_valid !== 1'b0 || alu_op !== 0 ||
                alu_a !== 0 || alu_b !== 0) begin
               failures++;
               $display("FAIL idle_issue iv=%b op=%0d a=%0d b=%0d exp all 0",
                        alu_in_valid, alu_op, alu_a, alu_b);
            end
         end else begin
            nbits = $countones(req_ready);
            gid = 0;
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) gid = i;
            gop = req_op[gid*3 +: 3];
            ga  = req_a[gid*6 +: 6];
            gb  = req_b[gid*6 +: 6];
            if (nbits != 1 || !req_valid[gid] ||
                alu_in_valid !== 1'b1 || alu_op !== gop ||
                alu_a !== ga || alu_b !== gb) begin
               failures++;
               $display("FAIL issue ready=%b valid=%b iv=%b op=%0d a=%0d b=%0d exp op=%0d a=%0d b=%0d",
                        req_ready, req_valid, alu_in_valid, alu_op,
                        alu_a, alu_b, gop, ga, gb);
            end
            e.id   = gid;
            e.data = model(gop, ga, gb);
            e.err  = (gop > 3'd2);
            e.due  = cyc + 2;
            sb.push_back(e);
         end
      end
   end

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(int i, logic [2:0] op,
                          logic [5:0] a, logic [5:0] b);
      req_valid[i] = 1'b1;
      req_op[i*3 +: 3] = op;
      req_a[i*6 +: 6] = a;
      req_b[i*6 +: 6] = b;
   endtask

   task automatic clr_req(int i);
      req_valid[i] = 1'b0;
      req_op[i*3 +: 3] = 3'd0;
      req_a[i*6 +: 6] = 6'd0;
      req_b[i*6 +: 6] = 6'd0;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset;
      req_valid = 4'hF;
      #2;
      checks++;
      if (req_ready !== 0 || alu_in_valid !== 0 ||
          alu_op !== 0 || alu_a !== 0 || alu_b !== 0) begin
         failures++;
         $display("FAIL reset_issue ready=%b iv=%b op=%0d a=%0d b=%0d exp 0",
                  req_ready, alu_in_valid, alu_op, alu_a, alu_b);
      end
      checks++;
      if (rsp_valid !== 0 || rsp_data !== 0 || rsp_err !== 0 ||
          busy !== 0 || tag_err !== 0) begin
         failures++;
         $display("FAIL reset_rsp v=%b d=%0d e=%b busy=%b tag_err=%b exp 0",
                  rsp_valid, rsp_data, rsp_err, busy, tag_err);
      end
      req_valid = 4'h0;
      do_reset();
   endtask

   task automatic test_single;
      set_req(0, 3'd0, 6'd63, 6'd1);
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0001) begin
         failures++;
         $display("FAIL single_ready got=%b exp=0001", req_ready);
      end
      next_cycle();
      clr_req(0);
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || rsp_valid !== 0) begin
         failures++;
         $display("FAIL single_mid busy=%b rsp=%b exp 1/0000",
                  busy, rsp_valid);
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 4'b0001 || rsp_data !== 7'd64 ||
          rsp_err !== 1'b0) begin
         failures++;
         $display("FAIL single_rsp v=%b d=%0d e=%b exp 0001/64/0",
                  rsp_valid, rsp_data, rsp_err);
      end
      next_cycle();
   endtask

   task automatic test_sub_mul;
      set_req(1, 3'd1, 6'd5, 6'd7);
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0010) begin
         failures++;
         $display("FAIL sub_ready got=%b exp=0010", req_ready);
      end
      next_cycle();
      clr_req(1);
      set_req(2, 3'd2, 6'd7, 6'd9);
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0100) begin
         failures++;
         $display("FAIL mul_ready got=%b exp=0100", req_ready);
      end
      next_cycle();
      clr_req(2);
      set_req(2, 3'd2, 6'd63, 6'd63);
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0100 || rsp_valid !== 4'b0010 ||
          rsp_data !== 7'd126) begin
         failures++;
         $display("FAIL sub_rsp ready=%b v=%b d=%0d exp 0100/0010/126",
                  req_ready, rsp_valid, rsp_data);
      end
      next_cycle();
      clr_req(2);
      @(negedge clk);
      checks++;
      if (rsp_valid !== 4'b0100 || rsp_data !== 7'd63) begin
         failures++;
         $display("FAIL mul_rsp v=%b d=%0d exp 0100/63",
                  rsp_valid, rsp_data);
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 4'b0100 || rsp_data !== 7'd1) begin
         failures++;
         $display("FAIL mul_wrap v=%b d=%0d exp 0100/1",
                  rsp_valid, rsp_data);
      end
      next_cycle();
   endtask

   task automatic test_fairness;
      logic [3:0] exp_g;
      do_reset();
      set_req(0, 3'd0, 6'd10, 6'd20);
      set_req(1, 3'd1, 6'd3,  6'd9);
      set_req(2, 3'd2, 6'd12, 6'd11);
      set_req(3, 3'd0, 6'd63, 6'd63);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         exp_g = 4'b0001 << (k % 4);
         checks++;
         if (req_ready !== exp_g) begin
            failures++;
            $display("FAIL fair_grant k=%0d got=%b exp=%b",
                     k, req_ready, exp_g);
         end
         next_cycle();
         if (k >= 4) clr_req(k % 4);
      end
      repeat (3) next_cycle();
   endtask

   task automatic test_hold_skip;
      set_req(0, 3'd0, 6'd1, 6'd2);
      @(negedge clk);
      next_cycle();
      clr_req(0);
      set_req(0, 3'd0, 6'd4, 6'd4);
      set_req(3, 3'd1, 6'd0, 6'd1);
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b1000) begin
         failures++;
         $display("FAIL skip_first got=%b exp=1000", req_ready);
      end
      next_cycle();
      clr_req(3);
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0001) begin
         failures++;
         $display("FAIL skip_wrap got=%b exp=0001", req_ready);
      end
      next_cycle();
      clr_req(0);
      set_req(1, 3'd2, 6'd2, 6'd3);
      @(negedge clk);
      next_cycle();
      clr_req(1);
      hold = 1'b1;
      set_req(0, 3'd0, 6'd7, 6'd8);
      set_req(2, 3'd1, 6'd9, 6'd1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (req_ready !== 4'b0000 ||
             busy !== ((k < 2) ? 1'b1 : 1'b0)) begin
            failures++;
            $display("FAIL hold k=%0d ready=%b busy=%b exp 0000/%0d",
                     k, req_ready, busy, (k < 2) ? 1 : 0);
         end
         next_cycle();
      end
      hold = 1'b0;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0100) begin
         failures++;
         $display("FAIL hold_ptr got=%b exp=0100", req_ready);
      end
      next_cycle();
      clr_req(2);
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0001) begin
         failures++;
         $display("FAIL hold_next got=%b exp=0001", req_ready);
      end
      next_cycle();
      clr_req(0);
      repeat (2) next_cycle();
   endtask

   task automatic test_illegal;
      set_req(0, 3'd3, 6'd5, 6'd5);
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0001) begin
         failures++;
         $display("FAIL ill_ready got=%b exp=0001", req_ready);
      end
      next_cycle();
      clr_req(0);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (rsp_valid !== 4'b0001 || rsp_data !== 7'd0 ||
          rsp_err !== 1'b1) begin
         failures++;
         $display("FAIL ill_rsp v=%b d=%0d e=%b exp 0001/0/1",
                  rsp_valid, rsp_data, rsp_err);
      end
      next_cycle();
   endtask

   task automatic test_tag_err;
      int n = 0;
      while (busy !== 1'b0 && n < 10) begin
         next_cycle();
         n++;
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || tag_err !== 1'b0) begin
         failures++;
         $display("FAIL tag_idle busy=%b tag_err=%b exp 0/0",
                  busy, tag_err);
      end
      next_cycle();
      force_ov = 1'b1;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 4'b0000) begin
         failures++;
         $display("FAIL tag_rsp got=%b exp=0000", rsp_valid);
      end
      next_cycle();
      force_ov = 1'b0;
      @(negedge clk);
      checks++;
      if (tag_err !== 1'b1) begin
         failures++;
         $display("FAIL tag_set got=%b exp=1", tag_err);
      end
      repeat (3) next_cycle();
      checks++;
      if (tag_err !== 1'b1) begin
         failures++;
         $display("FAIL tag_sticky got=%b exp=1", tag_err);
      end
   endtask

   task automatic test_reset_midflight;
      int bad = 0;
      set_req(1, 3'd0, 6'd9, 6'd9);
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0010) begin
         failures++;
         $display("FAIL rmf_ready got=%b exp=0010", req_ready);
      end
      next_cycle();
      clr_req(1);
      rst = 1'b1;
      #1;
      checks++;
      if (busy !== 0 || rsp_valid !== 0 || rsp_data !== 0 ||
          tag_err !== 0 || req_ready !== 0 || alu_in_valid !== 0) begin
         failures++;
         $display("FAIL rmf_clear busy=%b v=%b d=%0d te=%b rdy=%b iv=%b exp 0",
                  busy, rsp_valid, rsp_data, tag_err, req_ready,
                  alu_in_valid);
      end
      next_cycle();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (rsp_valid !== 0) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL rmf_norsp got=%0d pulses exp=0", bad);
      end
      next_cycle();
      set_req(1, 3'd0, 6'd2, 6'd2);
      set_req(3, 3'd1, 6'd2, 6'd2);
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0010) begin
         failures++;
         $display("FAIL rmf_ptr got=%b exp=0010", req_ready);
      end
      next_cycle();
      clr_req(1);
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b1000) begin
         failures++;
         $display("FAIL rmf_next got=%b exp=1000", req_ready);
      end
      next_cycle();
      clr_req(3);
      repeat (3) next_cycle();
   endtask

   initial begin
      rst = 1'b1;
      hold = 1'b0;
      force_ov = 1'b0;
      req_valid = '0;
      req_op = '0;
      req_a = '0;
      req_b = '0;
      test_reset();
      test_single();
      test_sub_mul();
      test_fairness();
      test_hold_skip();
      test_illegal();
      test_tag_err();
      test_reset_midflight();
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL sb_leftover got=%0d exp=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Shares one pipelined ALU datapath (registered inputs, registered outputs, fixed 2-cycle latency) between NREQ requesters.
- Round-robin arbitration with a valid/ready handshake on the request side.
- Issues at most one operation per cycle.
- Tracks in-flight requester IDs in a tag pipeline matched to the ALU latency, then routes each result back to its originator as a one-cycle response pulse.

Parameters:
- NREQ, 4, number of requesters (≥2).
- WIDTH, 6, operand width; result width is WIDTH+1.
- ALU_LAT, 2, cycles from alu_in_valid to alu_out_valid.
- IDW, $clog2(NREQ), requester ID width (derived).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- hold  in  1  when 1, no new grants; in-flight operations complete
- req_valid  in  NREQ  request pending, one bit per requester
- req_ready  out  NREQ  grant/accept, one-hot or zero
- req_op  in  NREQ*3  operation_t per requester (packed; slice i = requester i)
- req_a  in  NREQ*WIDTH  operand A per requester
- req_b  in  NREQ*WIDTH  operand B per requester
- alu_op  out  3  operation_t to ALU
- alu_a  out  WIDTH  operand A to ALU
- alu_b  out  WIDTH  operand B to ALU
- alu_in_valid  out  1  issue strobe to ALU
- alu_out  in  WIDTH+1  ALU result
- alu_out_valid  in  1  ALU result strobe
- rsp_valid  out  NREQ  one-hot response pulse
- rsp_data  out  WIDTH+1  response result, shared by all requesters
- rsp_err  out  1  response carries an illegal op
- busy  out  1  any operation in flight
- tag_err  out  1  sticky: alu_out_valid seen with no matching tag

Behaviour:
- Reset: req_ready=0, alu_in_valid=0, alu_op/a/b=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, tag_err=0; RR pointer=0; tag pipeline cleared.
- Handshake:
  - Transfer on req_valid[i] & req_ready[i].
  - Requester must hold req_op/a/b stable and req_valid high until the transfer.
  - Deasserting req_valid before the transfer is illegal.
- Arbitration is combinational:
  - Search req_valid starting at the pointer, ascending with wrap.
  - First set bit wins and receives req_ready.
  - hold=1 forces req_ready=0.
- Pointer update:
  - On a grant to i, pointer <= (i+1) mod NREQ.
  - With no grant, the pointer is unchanged.
- Issue:
  - alu_op/a/b/in_valid are combinational from the winner (muxed payload, in_valid = grant).
  - This drives the ALU's input register in the same cycle.
  - With no grant, alu_in_valid=0 and operands are driven to 0.
- Tag pipeline:
  - ALU_LAT-deep shift register of {valid, id, illegal}.
  - Stage 0 loads at grant; illegal = op not in {add, sub, mul}.
  - An illegal op is still issued; the ALU returns 0.
- Response (combinational from the last tag stage and ALU outputs):
  - When alu_out_valid & last-stage valid: rsp_valid[id]=1, rsp_data=alu_out, rsp_err=illegal.
  - Otherwise rsp_valid=0 and rsp_data=0.
  - Total request-to-response latency is ALU_LAT cycles after the accepting edge.
- tag_err:
  - Set when alu_out_valid ≠ last-stage valid.
  - Cleared only by reset.
- busy = OR of all tag-stage valids.
- Throughput:
  - One grant per cycle, back-to-back.
  - No response backpressure; requesters must always sink responses.
- hold:
  - Asserting mid-stream blocks new grants only; pending tags drain normally.
  - The pointer is frozen while hold=1.
- Simultaneous events: a new grant and a response in the same cycle are independent; the same requester may do both.
- Reset mid-operation:
  - Tags are dropped and no response is produced.
  - The ALU shares rst, so its pipeline clears too.
- Arithmetic: results are modulo 2^(WIDTH+1), as produced by the ALU; the arbiter never alters data.

Decomposition:
- alu_types_pkg holds operation_t and add/sub/mul encodings.
- Add to that package a helper function is_legal_op(operation_t).
- Sub-module rr_arbiter #(NREQ): inputs req, pointer, enable; output one-hot grant. The pointer register stays in the parent.

Test Plan:
- Single: req0 add a=63 b=1 -> req_ready[0] in the same cycle; rsp_valid[0] two cycles later, rsp_data=64; rsp_err=0.
- Sub and mul:
  - req1 sub a=5 b=7 -> rsp_valid[1], rsp_data=126.
  - req2 mul a=7 b=9 -> rsp_data=63.
  - req2 mul a=63 b=63 -> rsp_data=1.
- Fairness: all four req_valid held high for 8 cycles -> grants 0,1,2,3,0,1,2,3, one per cycle; rsp_valid matches each ID two cycles later.
- Hold and skip:
  - With pointer=1 and only req0/req3 valid -> grant 3, then 0.
  - Assert hold for 3 cycles -> no req_ready; busy drops after 2 cycles; pointer unchanged.
- Illegal op and fault:
  - req0 op encoding 3 -> response with rsp_data=0, rsp_err=1.
  - Forced alu_out_valid with an empty pipeline -> tag_err=1 and stays set.
- Reset mid-flight: assert rst one cycle after a grant -> all outputs 0 immediately; no rsp_valid afterwards; pointer=0.
